// File: rtl/stream_transpose_pkg.sv
// Shared sizing and types for the stream_transpose corner-turn buffer.
// Element count and width live here so the bank and top agree on one row layout.
package stream_transpose_pkg;

    localparam int NUM = 4;
    localparam int W   = 16;
    localparam int CW  = $clog2(NUM);

    typedef logic [NUM*W-1:0] row_t;
    typedef logic [CW-1:0]    idx_t;
    typedef logic             bank_idx_t;

endpackage

// File: rtl/stream_transpose_bank.sv
// One NUM x NUM element bank: row-wide write port, column-wide read mux.
// Storage clears on reset so the idle output column reads as zero.
module tp_bank
    import stream_transpose_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  idx_t wr_row,
    input  row_t wr_data,
    input  idx_t rd_col,
    output row_t rd_data
);

    row_t rows_q [NUM];
    row_t rows_d [NUM];

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            rows_d[k] = rows_q[k];
        end
        if (wr_en) begin
            rows_d[wr_row] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                rows_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM; k++) begin
                rows_q[k] <= rows_d[k];
            end
        end
    end

    // Column j gathers element j of every stored row; row k lands in slot k.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM; k++) begin
            rd_data[k*W +: W] = rows_q[k][rd_col*W +: W];
        end
    end

endmodule

// File: rtl/stream_transpose.sv
// Ping-pong corner-turn buffer: rows in one per cycle, columns out one per cycle.
// Outputs depend only on registered pointers, counters, flags and storage.
module stream_transpose
    import stream_transpose_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NUM*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NUM*W-1:0] out_data,
    output logic           out_last
);

    bank_idx_t wb_q, wb_d;
    bank_idx_t rb_q, rb_d;
    idx_t      wr_q, wr_d;
    idx_t      rc_q, rc_d;
    logic [1:0] full_q, full_d;

    logic in_fire;
    logic out_fire;
    logic [1:0] bank_we;
    row_t rd_data0;
    row_t rd_data1;

    assign in_ready  = ~full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign out_last  = out_valid & (rc_q == idx_t'(NUM-1));
    assign out_data  = rb_q ? rd_data1 : rd_data0;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign bank_we[0] = in_fire & (wb_q == 1'b0);
    assign bank_we[1] = in_fire & (wb_q == 1'b1);

    // Writer and reader touch different flags whenever both fire, so the
    // set and clear below never collide on one bank.
    always_comb begin
        wb_d   = wb_q;
        rb_d   = rb_q;
        wr_d   = wr_q;
        rc_d   = rc_q;
        full_d = full_q;
        if (in_fire) begin
            wr_d = wr_q + idx_t'(1);
            if (wr_q == idx_t'(NUM-1)) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end
        if (out_fire) begin
            rc_d = rc_q + idx_t'(1);
            if (rc_q == idx_t'(NUM-1)) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wr_q   <= '0;
            rc_q   <= '0;
            full_q <= '0;
        end else begin
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wr_q   <= wr_d;
            rc_q   <= rc_d;
            full_q <= full_d;
        end
    end

    tp_bank u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bank_we[0]),
        .wr_row  (wr_q),
        .wr_data (in_data),
        .rd_col  (rc_q),
        .rd_data (rd_data0)
    );

    tp_bank u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bank_we[1]),
        .wr_row  (wr_q),
        .wr_data (in_data),
        .rd_col  (rc_q),
        .rd_data (rd_data1)
    );

endmodule

// File: tb/tb_stream_transpose.sv
// Directed bench for stream_transpose: element value {4'h0, block, row, col}.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_stream_transpose;

    localparam int NUM = 4;
    localparam int W   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NUM*W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [NUM*W-1:0] out_data;
    logic            out_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_transpose dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    function automatic logic [NUM*W-1:0] row_val(input int b, input int r);
        logic [NUM*W-1:0] v;
        v = '0;
        for (int e = 0; e < NUM; e++) begin
            v[e*W +: W] = {4'h0, 4'(b), 4'(r), 4'(e)};
        end
        return v;
    endfunction

    function automatic logic [NUM*W-1:0] col_val(input int b, input int j);
        logic [NUM*W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM; k++) begin
            v[k*W +: W] = {4'h0, 4'(b), 4'(k), 4'(j)};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_col(input string tag, input int b, input int j);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data, col_val(b, j));
        chk({tag, "_last"}, 64'(out_last), 64'(j == NUM-1));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
    endtask

    initial begin
        int j;
        int t;
        logic [15:0] stall_pat;

        // Reset state
        #1;
        chk_idle("reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // Basic: four back-to-back rows, first column one cycle after the fourth row
        out_ready = 1'b1;
        for (int r = 0; r < NUM; r++) begin
            in_valid = 1'b1;
            in_data  = row_val(0, r);
            chk("basic_in_ready", 64'(in_ready), 64'd1);
            chk("basic_no_early_valid", 64'(out_valid), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < NUM; c++) begin
            chk_col("basic_col", 0, c);
            tick();
        end
        chk("basic_drained", 64'(out_valid), 64'd0);

        // Streaming: eight blocks back to back, no bubbles either side
        for (t = 0; t < 8*NUM + NUM; t++) begin
            if (t < 8*NUM) begin
                in_valid = 1'b1;
                in_data  = row_val(t / NUM, t % NUM);
                chk("stream_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (t >= NUM) begin
                chk_col("stream_col", (t - NUM) / NUM, (t - NUM) % NUM);
            end else begin
                chk("stream_lead_idle", 64'(out_valid), 64'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure: fill both banks with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 2*NUM; i++) begin
            in_valid = 1'b1;
            in_data  = row_val(1 + i / NUM, i % NUM);
            chk("bp_fill_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = row_val(3, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk_col("bp_held_col", 1, 0);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < NUM; c++) begin
            chk("bp_drain_in_ready", 64'(in_ready), 64'd0);
            chk_col("bp_drain_col", 1, c);
            tick();
        end
        // Bank freed: block 3 streams in while block 2 streams out
        for (int c = 0; c < NUM; c++) begin
            in_valid = 1'b1;
            in_data  = row_val(3, c);
            chk("bp_reopen_in_ready", 64'(in_ready), 64'd1);
            chk_col("bp_second_col", 2, c);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < NUM; c++) begin
            chk_col("bp_third_col", 3, c);
            tick();
        end
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Output stall: irregular out_ready, each column seen exactly once
        out_ready = 1'b0;
        for (int r = 0; r < NUM; r++) begin
            in_valid = 1'b1;
            in_data  = row_val(4, r);
            tick();
        end
        in_valid  = 1'b0;
        stall_pat = 16'b1011_0010_0110_1001;
        j = 0;
        t = 0;
        while (j < NUM && t < 16) begin
            out_ready = stall_pat[t];
            chk_col("stall_col", 4, j);
            if (stall_pat[t]) j++;
            t++;
            tick();
        end
        out_ready = 1'b1;
        chk("stall_all_cols", 64'(j), 64'(NUM));
        chk("stall_drained", 64'(out_valid), 64'd0);

        // Input gaps: one row every third cycle
        for (int r = 0; r < NUM; r++) begin
            in_valid = 1'b1;
            in_data  = row_val(0, r);
            chk("gap_no_early_valid", 64'(out_valid), 64'd0);
            tick();
            in_valid = 1'b0;
            in_data  = row_val(9, 9);
            if (r < NUM-1) begin
                for (int g = 0; g < 2; g++) begin
                    chk("gap_idle_valid", 64'(out_valid), 64'd0);
                    tick();
                end
            end
        end
        for (int c = 0; c < NUM; c++) begin
            chk_col("gap_col", 0, c);
            tick();
        end
        chk("gap_drained", 64'(out_valid), 64'd0);

        // Reset mid-block: block 5 draining, block 6 half written
        for (int r = 0; r < NUM; r++) begin
            in_valid = 1'b1;
            in_data  = row_val(5, r);
            tick();
        end
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1;
            in_data  = row_val(6, r);
            chk_col("rst_pre_col", 5, r);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        tick();
        chk_idle("rst_held");
        rst_n = 1'b1;
        tick();
        chk_idle("rst_release");
        for (int r = 0; r < NUM; r++) begin
            in_valid = 1'b1;
            in_data  = row_val(7, r);
            chk("rst_fresh_no_stale", 64'(out_valid), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < NUM; c++) begin
            chk_col("rst_fresh_col", 7, c);
            tick();
        end
        chk("rst_fresh_drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
